// File: rtl/ecc_mem_ctrl_if.sv
// Request/response port between the CPU memory stage and the SECDED memory controller.
// The master drives requests; the slave (controller) answers with one-cycle response strobes.
interface ecc_mem_ctrl_if #(
  parameter int ADDR_W = 5
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wd;
  logic              rsp_valid;
  logic [31:0]       rsp_rd;
  logic [1:0]        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wd,
    input  req_ready, rsp_valid, rsp_rd, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wd,
    output req_ready, rsp_valid, rsp_rd, rsp_err
  );
endinterface

// File: rtl/ecc_mem_ctrl.sv
// SECDED Hamming (39,32) controller: encodes writes, corrects/flags reads, optionally scrubs
// single-bit errors back to memory and keeps saturating error counters.
module ecc_mem_ctrl #(
  parameter int ADDR_W   = 5,
  parameter bit SCRUB_EN = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  ecc_mem_ctrl_if.slave     bus,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [38:0]       mem_wd,
  input  logic [38:0]       mem_rd,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_SCRUB} state_t;

  // Elaboration-time helpers describing the codeword layout.
  function automatic bit is_pow2(input int i);
    return (i & (i - 1)) == 0;
  endfunction

  function automatic int data_idx(input int pos);
    int n;
    n = 0;
    for (int i = 3; i < pos; i++) begin
      if (!is_pow2(i)) n++;
    end
    return n;
  endfunction

  // Positions 1..38 whose index has bit k set; optionally excluding the check bit itself.
  function automatic logic [38:0] pos_mask(input int k, input bit excl_self);
    logic [38:0] m;
    m = '0;
    for (int i = 1; i < 39; i++) begin
      if (((i >> k) & 1) == 1 && !(excl_self && i == (1 << k))) m = m | (39'd1 << i);
    end
    return m;
  endfunction

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [38:0]       cw_reg;
  logic [CNT_W-1:0]  cnt_corr_reg, cnt_uncorr_reg;

  // ---------------- encoder ----------------
  logic [38:0] enc_data;
  logic [5:0]  enc_chk;
  logic [38:0] enc_cw;

  for (genvar gi = 0; gi < 39; gi++) begin : g_enc_place
    if (gi == 0 || is_pow2(gi)) begin : g_hole
      assign enc_data[gi] = 1'b0;
    end else begin : g_bit
      assign enc_data[gi] = bus.req_wd[data_idx(gi)];
    end
  end

  for (genvar gi = 0; gi < 6; gi++) begin : g_enc_chk
    assign enc_chk[gi] = ^(enc_data & pos_mask(gi, 1'b1));
  end

  for (genvar gi = 0; gi < 39; gi++) begin : g_enc_cw
    if (gi == 0) begin : g_par
      assign enc_cw[gi] = (^enc_data) ^ (^enc_chk);
    end else if (is_pow2(gi)) begin : g_chk
      assign enc_cw[gi] = enc_chk[$clog2(gi)];
    end else begin : g_dat
      assign enc_cw[gi] = enc_data[gi];
    end
  end

  // ---------------- decoder ----------------
  logic [5:0]  syn;
  logic        par;
  logic        dec_corr, dec_uncorr;
  logic [38:0] flip, corr_cw;
  logic [31:0] dec_data;

  for (genvar gi = 0; gi < 6; gi++) begin : g_syn
    assign syn[gi] = ^(mem_rd & pos_mask(gi, 1'b0));
  end

  assign par        = ^mem_rd;
  assign dec_corr   = par && (syn <= 6'd38);
  assign dec_uncorr = (!par && syn != 6'd0) || (par && syn > 6'd38);

  // A syndrome of 0 with odd parity flips only c[0], leaving the data untouched.
  for (genvar gi = 0; gi < 39; gi++) begin : g_flip
    assign flip[gi] = dec_corr && (syn == 6'(gi));
  end

  assign corr_cw = mem_rd ^ flip;

  for (genvar gi = 3; gi < 39; gi++) begin : g_extract
    if (!is_pow2(gi)) begin : g_bit
      assign dec_data[data_idx(gi)] = corr_cw[gi];
    end
  end

  // ---------------- state register and datapath latches ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      cw_reg         <= '0;
      cnt_corr_reg   <= '0;
      cnt_uncorr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && bus.req_valid) begin
        addr_reg <= bus.req_addr;
        cw_reg   <= enc_cw;
      end
      if (state_reg == ST_READ) begin
        if (dec_corr) begin
          cw_reg <= corr_cw;
          if (cnt_corr_reg != {CNT_W{1'b1}}) cnt_corr_reg <= cnt_corr_reg + CNT_W'(1);
        end
        if (dec_uncorr && cnt_uncorr_reg != {CNT_W{1'b1}}) begin
          cnt_uncorr_reg <= cnt_uncorr_reg + CNT_W'(1);
        end
      end
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (bus.req_valid) state_next = bus.req_we ? ST_WRITE : ST_READ;
      ST_WRITE: state_next = ST_IDLE;
      ST_READ:  state_next = (dec_corr && SCRUB_EN) ? ST_SCRUB : ST_IDLE;
      ST_SCRUB: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  logic        req_ready_next;
  logic        rsp_valid_next;
  logic [31:0] rsp_rd_next;
  logic [1:0]  rsp_err_next;

  always_comb begin
    req_ready_next = 1'b0;
    rsp_valid_next = 1'b0;
    rsp_rd_next    = '0;
    rsp_err_next   = 2'b00;
    mem_we         = 1'b0;
    mem_addr       = addr_reg;
    mem_wd         = '0;
    case (state_reg)
      ST_IDLE: req_ready_next = 1'b1;
      ST_WRITE: begin
        mem_we         = ~rst;
        mem_wd         = cw_reg;
        rsp_valid_next = ~rst;
      end
      ST_READ: begin
        rsp_valid_next = ~rst;
        rsp_rd_next    = dec_data;
        rsp_err_next   = {dec_uncorr, dec_corr};
      end
      ST_SCRUB: begin
        mem_we = ~rst;
        mem_wd = cw_reg;
      end
      default: ;
    endcase
  end

  assign bus.req_ready = req_ready_next;
  assign bus.rsp_valid = rsp_valid_next;
  assign bus.rsp_rd    = rsp_rd_next;
  assign bus.rsp_err   = rsp_err_next;
  assign cnt_corr      = cnt_corr_reg;
  assign cnt_uncorr    = cnt_uncorr_reg;

endmodule
